// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard shared types: FSM states and failure codes.
// Optional timeout feature: WB_SCOREBOARD_TIMEOUT_EN.
package wb_scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_MISMATCH = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;

endpackage

// File: rtl/wb_shadow_regfile.sv
// Shadow register file: one write, one read, x0 stays zero.
// Synchronous clear wipes every entry at the start of a run.
module wb_shadow_regfile #(
  parameter int XLEN  = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [NREGS];

  // storage: async reset, sync clear, x0 writes dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: mirrors register writes, then checks a table.
// Optional RUN timeout enabled by WB_SCOREBOARD_TIMEOUT_EN.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int XLEN        = 16,
  parameter int NREGS       = 8,
  parameter int MAX_COMMITS = 255,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             RegWriteEnW,
  input  logic [$clog2(NREGS)-1:0]         RdW,
  input  logic [XLEN-1:0]                  ResultW,
  input  logic                             start,
  input  logic [$clog2(MAX_COMMITS+1)-1:0] target,
  input  logic                             exp_we,
  input  logic [$clog2(NREGS)-1:0]         exp_idx,
  input  logic [XLEN-1:0]                  exp_val,
  input  logic                             exp_chk,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [1:0]                       fail_code,
  output logic [$clog2(NREGS)-1:0]         fail_idx,
  output logic [XLEN-1:0]                  fail_got,
  output logic [XLEN-1:0]                  fail_exp,
  output logic [$clog2(MAX_COMMITS+1)-1:0] commit_count
);

  localparam int IW = $clog2(NREGS);
  localparam int CW = $clog2(MAX_COMMITS+1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pass_q, pass_d;
  logic [1:0]      code_q, code_d;
  logic [IW-1:0]   fidx_q, fidx_d;
  logic [XLEN-1:0] got_q, got_d;
  logic [XLEN-1:0] fexp_q, fexp_d;
  logic [XLEN-1:0] ev [NREGS];
  logic [NREGS-1:0] ec;
  logic            clr, sh_we, tmo_hit;
  logic [XLEN-1:0] sh_rd, cmp_exp;

  wb_shadow_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .we    (sh_we),
    .waddr (RdW),
    .wdata (ResultW),
    .raddr (idx_q),
    .rdata (sh_rd)
  );

`ifdef WB_SCOREBOARD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tmo_q;

  // RUN cycle counter, cleared when a run is launched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else if (clr) tmo_q <= '0;
    else if (state_q == RUN) tmo_q <= tmo_q + TW'(1);
  end

  assign tmo_hit = (tmo_q + TW'(1)) == TW'(TIMEOUT);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  assign cnt_inc = (cnt_q == CW'(MAX_COMMITS)) ? cnt_q : cnt_q + CW'(1);
  assign cmp_exp = (idx_q == '0) ? '0 : ev[idx_q];

  // next state, commit counting, compare walk and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    code_d  = code_q;
    fidx_d  = fidx_q;
    got_d   = got_q;
    fexp_d  = fexp_q;
    clr     = 1'b0;
    sh_we   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          tgt_d   = target;
          idx_d   = '0;
          pass_d  = 1'b0;
          code_d  = FAIL_NONE;
          fidx_d  = '0;
          got_d   = '0;
          fexp_d  = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (tgt_q == '0) begin
          state_d = CHECK;
        end else if (RegWriteEnW) begin
          sh_we = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == tgt_q) state_d = CHECK;
        end
        if (state_d == RUN && tmo_hit) begin
          state_d = DONE;
          code_d  = FAIL_TIMEOUT;
          fidx_d  = '0;
          pass_d  = 1'b0;
        end
      end
      CHECK: begin
        if (ec[idx_q] && sh_rd != cmp_exp) begin
          state_d = DONE;
          code_d  = FAIL_MISMATCH;
          fidx_d  = idx_q;
          got_d   = sh_rd;
          fexp_d  = cmp_exp;
        end else if (idx_q == IW'(NREGS-1)) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      code_q  <= FAIL_NONE;
      fidx_q  <= '0;
      got_q   <= '0;
      fexp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      fidx_q  <= fidx_d;
      got_q   <= got_d;
      fexp_q  <= fexp_d;
    end
  end

  // expected table, writable only while no run is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ec <= '0;
      for (int i = 0; i < NREGS; i++) ev[i] <= '0;
    end else if (exp_we && (state_q == IDLE || state_q == DONE)) begin
      ev[exp_idx] <= exp_val;
      ec[exp_idx] <= exp_chk;
    end
  end

  assign busy         = (state_q == RUN) || (state_q == CHECK);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign fail_code    = code_q;
  assign fail_idx     = fidx_q;
  assign fail_got     = got_q;
  assign fail_exp     = fexp_q;
  assign commit_count = cnt_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed program runs plus random runs
// against a table-level reference model (WB_SCOREBOARD_TIMEOUT_EN aware).
module tb_wb_scoreboard;

  localparam int XLEN  = 16;
  localparam int NREGS = 8;
  localparam int MAXC  = 255;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteEnW = 1'b0;
  logic [2:0]  RdW = '0;
  logic [15:0] ResultW = '0;
  logic        start = 1'b0;
  logic [7:0]  target = '0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic [15:0] exp_val = '0;
  logic        exp_chk = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  fail_idx;
  logic [15:0] fail_got, fail_exp;
  logic [7:0]  commit_count;

  wb_scoreboard #(
    .XLEN        (XLEN),
    .NREGS       (NREGS),
    .MAX_COMMITS (MAXC),
    .TIMEOUT     (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWriteEnW  (RegWriteEnW),
    .RdW          (RdW),
    .ResultW      (ResultW),
    .start        (start),
    .target       (target),
    .exp_we       (exp_we),
    .exp_idx      (exp_idx),
    .exp_val      (exp_val),
    .exp_chk      (exp_chk),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_code    (fail_code),
    .fail_idx     (fail_idx),
    .fail_got     (fail_got),
    .fail_exp     (fail_exp),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_ev [8];
  logic        m_ec [8];
  logic [15:0] m_sh [8];
  int          m_cnt, m_code, m_idx, m_lat, m_pass, m_hang;
  logic [15:0] m_got, m_exp;

  int          nops;
  logic        op_we  [32];
  logic [2:0]  op_rd  [32];
  logic [15:0] op_val [32];
  int          done_lat;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tload(input int idx, input logic [15:0] val, input logic c);
    exp_we  = 1'b1;
    exp_idx = 3'(idx);
    exp_val = val;
    exp_chk = c;
    step();
    exp_we = 1'b0;
    m_ev[idx] = val;
    m_ec[idx] = c;
  endtask

  task automatic tclear_model();
    for (int j = 0; j < NREGS; j++) begin
      m_ev[j] = '0;
      m_ec[j] = 1'b0;
    end
  endtask

  task automatic load_prog_table();
    tload(0, 16'h0000, 1'b0);
    tload(1, 16'h00FF, 1'b1);
    tload(2, 16'h00F0, 1'b1);
    tload(3, 16'h00F0, 1'b1);
    tload(4, 16'h000F, 1'b1);
    tload(5, 16'h00FF, 1'b1);
    tload(6, 16'h00FA, 1'b1);
    tload(7, 16'h000F, 1'b1);
  endtask

  task automatic add_op(input logic we, input int rd, input logic [15:0] v);
    op_we[nops]  = we;
    op_rd[nops]  = 3'(rd);
    op_val[nops] = v;
    nops++;
  endtask

  // the seven-instruction program, results computed by hand
  task automatic add_prog();
    add_op(1'b1, 1, 16'h00FF);
    add_op(1'b1, 2, 16'h00F0);
    add_op(1'b1, 4, 16'h00FF & 16'h000F);
    add_op(1'b1, 7, 16'h00FF ^ 16'h00F0);
    add_op(1'b1, 3, 16'h00FF & 16'h00F0);
    add_op(1'b1, 6, 16'h00F0 | 16'h000A);
    add_op(1'b1, 5, 16'h00F0 | 16'h000F);
  endtask

  // reference: replay the op list by the scoreboard's rules
  task automatic model(input int tgt);
    int r;
    bit tmo;
    logic [15:0] e;
    r = 0;
    tmo = 1'b0;
    m_cnt = 0; m_hang = 0; m_code = 0; m_idx = 0;
    m_got = '0; m_exp = '0; m_pass = 0; m_lat = 0;
    for (int j = 0; j < NREGS; j++) m_sh[j] = '0;
    if (tgt == 0) begin
      r = 1;
    end else begin
      for (int i = 0; i < nops && r == 0; i++) begin
        if (op_we[i]) begin
          m_cnt++;
          if (op_rd[i] != 0) m_sh[op_rd[i]] = op_val[i];
          if (m_cnt == tgt) r = i + 1;
        end
`ifdef WB_SCOREBOARD_TIMEOUT_EN
        if (r == 0 && i + 1 == TMO) begin
          r = i + 1;
          tmo = 1'b1;
        end
`endif
      end
    end
    if (r == 0) begin
      m_hang = 1;
    end else if (tmo) begin
      m_code = 2;
      m_lat = r;
    end else begin
      m_pass = 1;
      m_lat = r + NREGS;
      for (int j = 0; j < NREGS; j++) begin
        e = (j == 0) ? 16'h0 : m_ev[j];
        if (m_ec[j] && m_sh[j] != e) begin
          m_pass = 0;
          m_code = 1;
          m_idx = j;
          m_got = m_sh[j];
          m_exp = e;
          m_lat = r + 1 + j;
          break;
        end
      end
    end
  endtask

  task automatic run(input int tgt, input bit sw, input int sw_idx,
                     input logic [15:0] sw_val, input bit sw_c);
    int lat;
    start  = 1'b1;
    target = 8'(tgt);
    if (sw) begin
      exp_we  = 1'b1;
      exp_idx = 3'(sw_idx);
      exp_val = sw_val;
      exp_chk = sw_c;
      m_ev[sw_idx] = sw_val;
      m_ec[sw_idx] = sw_c;
    end
    model(tgt);
    step();
    start  = 1'b0;
    exp_we = 1'b0;
    check("busy_after_start", busy, 1);
    lat = 0;
    done_lat = 0;
    for (int i = 0; i < nops; i++) begin
      RegWriteEnW = op_we[i];
      RdW         = op_rd[i];
      ResultW     = op_val[i];
      if (i == 0) begin
        exp_we  = 1'b1;
        exp_idx = 3'($urandom_range(1, 7));
        exp_val = 16'($urandom) | 16'h8000;
        exp_chk = 1'b1;
      end
      step();
      exp_we = 1'b0;
      lat++;
      if (done_lat == 0 && done) done_lat = lat;
    end
    RegWriteEnW = 1'b0;
    if (m_hang != 0) begin
      repeat (40) step();
      check("hang_busy", busy, 1);
      check("hang_done", done, 0);
      check("hang_no_tmo", (fail_code != 2'd2), 1);
      return;
    end
    for (int k = 0; k < 40 && done_lat == 0; k++) begin
      step();
      lat++;
      if (done) done_lat = lat;
    end
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("done_latency", done_lat, m_lat);
    check("pass", pass, m_pass);
    check("fail_code", fail_code, m_code);
    check("commit_count", commit_count, m_cnt);
    if (m_code == 1) begin
      check("fail_idx", fail_idx, m_idx);
      check("fail_got", fail_got, m_got);
      check("fail_exp", fail_exp, m_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int nw;
    int tg;
    tclear_model();
    #2 reset = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_code", fail_code, 0);
    check("rst_idx", fail_idx, 0);
    check("rst_got", fail_got, 0);
    check("rst_exp", fail_exp, 0);
    check("rst_count", commit_count, 0);
    reset = 1'b1;
    step();

    // program run: must pass with seven commits
    load_prog_table();
    nops = 0;
    add_prog();
    run(7, 0, 0, '0, 0);
    check("prog_pass", pass, 1);
    check("prog_count", commit_count, 7);

    // corrupted expectation for x5
    tload(5, 16'h00FE, 1'b1);
    run(7, 0, 0, '0, 0);
    check("mis_code", fail_code, 1);
    check("mis_idx", fail_idx, 5);
    check("mis_got", fail_got, 16'h00FF);
    check("mis_exp", fail_exp, 16'h00FE);

    // x0 write is counted but never stored
    for (int j = 0; j < NREGS; j++) tload(j, 16'h0, 1'b0);
    tload(0, 16'h0000, 1'b1);
    nops = 0;
    add_op(1'b1, 0, 16'h1234);
    run(1, 0, 0, '0, 0);
    check("x0_pass", pass, 1);
    check("x0_count", commit_count, 1);

    // target zero: straight to CHECK, nothing counted
    nops = 0;
    add_op(1'b1, 3, 16'h5555);
    add_op(1'b1, 4, 16'h6666);
    run(0, 0, 0, '0, 0);
    check("t0_count", commit_count, 0);

    // table write coinciding with start is used by the run
    load_prog_table();
    nops = 0;
    add_prog();
    run(7, 1, 5, 16'h00FE, 1);
    check("sw_idx", fail_idx, 5);
    tload(5, 16'h00FF, 1'b1);

    // only three writes toward a target of seven
    nops = 0;
    add_op(1'b1, 1, 16'h00FF);
    add_op(1'b1, 2, 16'h00F0);
    add_op(1'b1, 3, 16'h00F0);
    for (int i = 0; i < 17; i++) add_op(1'b0, 0, 16'h0);
    run(7, 0, 0, '0, 0);
`ifdef WB_SCOREBOARD_TIMEOUT_EN
    check("tmo_code", fail_code, 2);
    check("tmo_count", commit_count, 3);
    check("tmo_lat", done_lat, TMO);
`else
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    tclear_model();
    load_prog_table();
`endif

    // seventh commit lands on the last allowed RUN cycle
    nops = 0;
    for (int i = 0; i < TMO - 7; i++) add_op(1'b0, 0, 16'h0);
    add_prog();
    run(7, 0, 0, '0, 0);
    check("edge_pass", pass, 1);

    // reset in the middle of a run
    nops = 0;
    add_prog();
    start  = 1'b1;
    target = 8'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RegWriteEnW = op_we[i];
      RdW         = op_rd[i];
      ResultW     = op_val[i];
      step();
    end
    RegWriteEnW = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_pass", pass, 0);
    check("mid_code", fail_code, 0);
    check("mid_count", commit_count, 0);
    check("mid_got", fail_got, 0);
    tclear_model();
    step();
    reset = 1'b1;
    step();
    load_prog_table();
    run(7, 0, 0, '0, 0);
    check("mid_rerun_pass", pass, 1);

    // random runs
    for (int it = 0; it < 25; it++) begin
      nops = 24;
      nw = 0;
      for (int i = 0; i < nops; i++) begin
        op_we[i]  = ($urandom_range(0, 9) < 7);
        op_rd[i]  = 3'($urandom_range(0, 7));
        op_val[i] = 16'($urandom);
        if (op_we[i]) nw++;
      end
      tg = $urandom_range(0, nw);
      model(tg);
      for (int j = 0; j < NREGS; j++) begin
        if ($urandom_range(0, 3) != 0)
          tload(j, m_sh[j], 1'($urandom_range(0, 1)));
        else
          tload(j, 16'($urandom), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0)
        run(tg, 1, $urandom_range(0, 7), 16'($urandom), 1);
      else
        run(tg, 0, 0, '0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

- Synthesizable self-checking writeback scoreboard for the pipelined processor.
- Taps the writeback-stage register-write port and mirrors every architectural write into a shadow register file.
- Counts retired writes and, once a programmed commit target is reached, compares the shadow against a loaded expected-value table.
- Replaces fixed-delay register peeking in benches; can also sit on-chip as a self-test monitor.

## Interface
Parameters:
- XLEN, 16, data width of a register / writeback result
- NREGS, 8, architectural registers mirrored (x0 included, hardwired zero)
- MAX_COMMITS, 255, largest programmable commit target
- TIMEOUT, 1024, cycles allowed in RUN before forced failure

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- RegWriteEnW  in  1  writeback register-write enable
- RdW  in  $clog2(NREGS)  writeback destination index
- ResultW  in  XLEN  writeback data
- start  in  1  one-cycle pulse, begins a run
- target  in  $clog2(MAX_COMMITS+1)  commit count to wait for; sampled on start
- exp_we  in  1  expected-table write strobe
- exp_idx  in  $clog2(NREGS)  expected-table index
- exp_val  in  XLEN  expected value
- exp_chk  in  1  1 = check this register, 0 = don't-care
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  valid while done
- fail_code  out  2  0 none, 1 mismatch, 2 timeout
- fail_idx  out  $clog2(NREGS)  first mismatching register
- fail_got  out  XLEN  shadow value at fail_idx
- fail_exp  out  XLEN  expected value at fail_idx
- commit_count  out  $clog2(MAX_COMMITS+1)  writes retired this run

## Operation
FSM states:
- IDLE: waits for start.
- RUN: start moves IDLE→RUN. Also legal from DONE, which restarts.
  - start is ignored in RUN and CHECK.
  - On entry, the shadow file, commit_count and the timeout counter clear to 0.
  - Each cycle with RegWriteEnW=1, commit_count increments, including RdW=0.
  - The shadow file is written only when RdW≠0.
  - RUN→CHECK on the cycle commit_count reaches target. The write on that cycle is included.
  - target=0 goes RUN→CHECK after one cycle, with no commits counted.
- CHECK: compares one index per cycle, from 0 to NREGS-1, for entries with chk=1.
  - On the first mismatch, latch fail_idx, fail_got and fail_exp, set fail_code=1 and go to DONE.
  - After the last index, go to DONE with pass=1.
  - Writeback activity during CHECK is ignored.
- DONE: results hold until the next start or reset.

Expected table:
- Writes are accepted only in IDLE or DONE and ignored otherwise.
- Contents persist across runs.
- Entry 0 compares against the constant 0.

Arithmetic and saturation:
- commit_count saturates at MAX_COMMITS.
- Shadow values are stored unmodified at XLEN width.

## Timing
Reset (async assert, sync-safe deassert) forces:
- State IDLE.
- busy=0, done=0, pass=0, fail_code=0, fail_idx=0, fail_got=0, fail_exp=0, commit_count=0.
- Shadow file all 0.
- Expected table all chk=0, value 0.

Latency:
- start at edge N gives busy=1 from N+1.
- A write retiring at edge M is visible in commit_count after M.
- CHECK lasts at most NREGS cycles.
- done rises one cycle after the deciding compare.

Same-cycle priorities:
- Target reached and timeout expire in the same cycle: target wins, go to CHECK.
- exp_we together with start: the write lands, and the run uses the new value.

Reset mid-run: returns to IDLE immediately and the table is lost.

## Configuration
WB_SCOREBOARD_TIMEOUT_EN:
- Defined: a cycle counter runs in RUN. When it reaches TIMEOUT, go to DONE with pass=0, fail_code=2 and fail_idx=0.
- Undefined: no counter; RUN waits indefinitely and fail_code never equals 2.

## Structure
Package wb_scoreboard_pkg holds:
- State enum: IDLE, RUN, CHECK, DONE.
- fail_code localparams: FAIL_NONE, FAIL_MISMATCH, FAIL_TIMEOUT.

One sub-module, wb_shadow_regfile:
- One write port, one read port.
- x0 write-suppressed.
- Synchronous clear.

## Test plan
- Program addiw x1,x0,0xFF; addiw x2,x0,0xF0; andi x4,x1,0x0F; xor x7,x1,x2; and x3,x1,x2; ori x6,x2,0x0A; or x5,x3,x4.
  - Expect x1=FF, x2=F0, x3=F0, x4=0F, x5=FF, x6=FA, x7=0F; target=7.
  - Required response: done, pass=1, commit_count=7.
- Same program with expected x5=0xFE → fail_code=1, fail_idx=5, fail_got=0x00FF, fail_exp=0x00FE.
- Write to x0 with 0x1234, expected chk x0 → pass=1; commit_count increments by 1.
- With TIMEOUT_EN, TIMEOUT=16, target=7, only 3 writes driven → done after 16 RUN cycles, fail_code=2, commit_count=3.
- Seventh commit lands on the cycle the timeout counter hits TIMEOUT → CHECK entered, pass=1.
- Assert reset low mid-RUN after 4 commits → all outputs 0, state IDLE; a new start with a reloaded table passes.
